// File: rtl/core_if_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_if_pkg                                                              |
// | Shared types and constants for the RV32I instruction-fetch stage.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package core_if_pkg;

   // Fetch FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } if_state_e;

   localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_INSTR    = 32'h0000_0013;   // addi x0,x0,0

   // One fetched instruction together with its bookkeeping
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_entry_t;

   // The low two PC bits alone decide misalignment
   function automatic logic is_misaligned(input logic [1:0] pc_lo);
      return pc_lo != 2'b00;
   endfunction

endpackage : core_if_pkg
`default_nettype wire

// File: rtl/core_if_holdbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_if_holdbuf                                                          |
// | One-entry skid buffer catching a response that arrives while IF/ID is    |
// | stalled. Flush wins over load; load and drain never coincide.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_if_holdbuf
   import core_if_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic         flush_i,
   input  fetch_entry_t entry_i,
   output fetch_entry_t entry_o
);

   fetch_entry_t entry_q;

   // Capture, release or discard the buffered instruction
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         entry_q <= '0;
      end else if (flush_i || drain_i) begin
         entry_q.valid <= 1'b0;
      end else if (load_i) begin
         entry_q <= entry_i;
      end
   end

   assign entry_o = entry_q;

endmodule : core_if_holdbuf
`default_nettype wire

// File: rtl/core_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_if_stage                                                            |
// | RV32I instruction fetch: PC register, single-outstanding imem fetch FSM, |
// | redirect kill flag, IF/ID pipeline register and stall skid buffer.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_if_stage
   import core_if_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
   parameter logic [31:0] NOP_INSTR    = IF_NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_o,
   input  logic [31:0] pc_next_i,
   input  logic        c_redirect_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_misalign_o
);

   if_state_e    state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         kill_q, kill_d;
   fetch_entry_t ifid_q, ifid_d;

   fetch_entry_t w_hb;
   fetch_entry_t w_rsp_entry;
   logic         w_outstanding;
   logic         w_rsp_any;
   logic         w_rsp_ok;
   logic         w_ifid_free;
   logic         w_hb_load;
   logic         w_hb_drain;
   logic         w_imem_req;

   // A response is only expected in WAIT while the buffer is empty; a full
   // buffer in WAIT means we are parked waiting for it to drain.
   assign w_outstanding = (state_q == ST_WAIT) && !w_hb.valid;
   assign w_rsp_any     = w_outstanding && imem_rvalid_i;
   assign w_rsp_ok      = w_rsp_any && !kill_q && !c_redirect_i;
   assign w_ifid_free   = !ifid_q.valid || !stall_i;
   assign w_hb_load     = w_rsp_ok && !w_ifid_free;
   assign w_hb_drain    = w_hb.valid && w_ifid_free;

   // The instruction belongs to the PC that was fetched, which is still pc_q
   assign w_rsp_entry = '{valid:    1'b1,
                          pc:       pc_q,
                          instr:    imem_rdata_i,
                          misalign: is_misaligned(pc_q[1:0])};

   core_if_holdbuf u_holdbuf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (w_hb_load),
      .drain_i (w_hb_drain),
      .flush_i (c_redirect_i),
      .entry_i (w_rsp_entry),
      .entry_o (w_hb)
   );

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: fetch until the skid buffer fills, then wait for drain
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ:  if (imem_gnt_i) state_d = ST_WAIT;
         ST_WAIT: begin
            if (w_hb.valid) begin
               if (c_redirect_i || w_hb_drain) state_d = ST_REQ;
            end else if (imem_rvalid_i) begin
               if (!w_hb_load) state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_imem_req = (state_q == ST_REQ);
   end

   // PC advances on an accepted response or a redirect; kill tracks a
   // request that is already with the memory when a redirect arrives
   always_comb begin
      pc_d   = (c_redirect_i || w_rsp_ok) ? pc_next_i : pc_q;
      kill_d = kill_q;
      if (w_rsp_any) kill_d = 1'b0;
      if (c_redirect_i &&
          (((state_q == ST_REQ) && imem_gnt_i) || (w_outstanding && !imem_rvalid_i)))
         kill_d = 1'b1;
   end

   // IF/ID next value: flush, refill from buffer first, then from memory
   always_comb begin
      ifid_d = ifid_q;
      if (c_redirect_i) begin
         ifid_d.valid = 1'b0;
         ifid_d.instr = NOP_INSTR;
      end else if (w_ifid_free) begin
         if (w_hb.valid) begin
            ifid_d = w_hb;
         end else if (w_rsp_ok) begin
            ifid_d = w_rsp_entry;
         end else begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
         end
      end
   end

   // PC, kill flag and IF/ID registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q   <= RESET_VECTOR;
         kill_q <= 1'b0;
         ifid_q <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR, misalign: 1'b0};
      end else begin
         pc_q   <= pc_d;
         kill_q <= kill_d;
         ifid_q <= ifid_d;
      end
   end

   assign pc_o            = pc_q;
   assign imem_req_o      = w_imem_req;
   assign imem_addr_o     = {pc_q[31:2], 2'b00};
   assign ifid_valid_o    = ifid_q.valid;
   assign ifid_pc_o       = ifid_q.pc;
   assign ifid_instr_o    = ifid_q.instr;
   assign ifid_misalign_o = ifid_q.misalign;

endmodule : core_if_stage
`default_nettype wire

// File: tb/tb_core_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_if_stage                                                         |
// | Self-checking bench: bench-side memory and PC adder, in-order            |
// | instruction-stream reference model, directed scenarios then random run.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_core_if_stage;
   import core_if_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_o;
   logic [31:0] pc_next_i;
   logic        c_redirect_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_misalign_o;

   always #5 clk_i = ~clk_i;

   core_if_stage dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .pc_o            (pc_o),
      .pc_next_i       (pc_next_i),
      .c_redirect_i    (c_redirect_i),
      .stall_i         (stall_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_gnt_i      (imem_gnt_i),
      .imem_rvalid_i   (imem_rvalid_i),
      .imem_rdata_i    (imem_rdata_i),
      .ifid_valid_o    (ifid_valid_o),
      .ifid_pc_o       (ifid_pc_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_misalign_o (ifid_misalign_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Memory model: one outstanding request, grants only when idle
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_wait = 0;
   int          gnt_pct  = 100;
   int          lat_min  = 1;
   int          lat_max  = 1;
   bit          ovr_en   = 1'b0;
   logic [31:0] ovr_data = '0;

   // Reference model: the architectural instruction stream seen by decode
   logic [31:0] exp_pc = IF_RESET_VECTOR;
   int          cyc = 0;
   int          n_cons = 0;
   int          last_cons_cyc = 0;
   bit          gap_en = 1'b0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Set inputs for the coming edge from the bench memory and adder
   task automatic drive(input bit st, input bit rd, input logic [31:0] tgt);
      stall_i       = st;
      c_redirect_i  = rd;
      pc_next_i     = rd ? tgt : pc_o + 32'd4;
      imem_rvalid_i = mem_pend && (mem_wait == 0);
      imem_rdata_i  = imem_rvalid_i ? (ovr_en ? ovr_data : memf(mem_addr)) : $urandom;
      imem_gnt_i    = imem_req_o && !mem_pend && ($urandom_range(99) < gnt_pct);
   endtask

   // Check pre-edge state, advance one clock, check post-edge state
   task automatic tick();
      bit          hold_exp, req_hold, was_redir, was_rst;
      logic [31:0] s_pc, s_instr, s_addr;
      logic        s_mis;
      if (!rst_i) begin
         if (!ifid_valid_o) check("nop_when_invalid", ifid_instr_o, IF_NOP_INSTR);
         if (ifid_valid_o && !stall_i && !c_redirect_i) begin
            check("cons_pc", ifid_pc_o, exp_pc);
            check("cons_instr", ifid_instr_o, memf(exp_pc));
            check("cons_misalign", 32'(ifid_misalign_o), 32'(exp_pc[1:0] != 2'b00));
            if (gap_en && n_cons > 0) check("cadence", 32'(cyc - last_cons_cyc), 32'd2);
            exp_pc = exp_pc + 32'd4;
            n_cons++;
            last_cons_cyc = cyc;
         end
         if (c_redirect_i) exp_pc = pc_next_i;
      end
      hold_exp  = !rst_i && ifid_valid_o && stall_i && !c_redirect_i;
      req_hold  = !rst_i && imem_req_o && !imem_gnt_i && !c_redirect_i;
      was_redir = !rst_i && c_redirect_i;
      was_rst   = rst_i;
      s_pc      = ifid_pc_o;
      s_instr   = ifid_instr_o;
      s_mis     = ifid_misalign_o;
      s_addr    = imem_addr_o;
      if (imem_rvalid_i) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (imem_gnt_i) begin
         mem_pend = 1'b1;
         mem_addr = imem_addr_o;
         mem_wait = $urandom_range(lat_max - 1, lat_min - 1);
      end
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      if (was_rst) exp_pc = IF_RESET_VECTOR;
      if (hold_exp) begin
         check("stall_hold_valid", 32'(ifid_valid_o), 32'd1);
         check("stall_hold_pc", ifid_pc_o, s_pc);
         check("stall_hold_instr", ifid_instr_o, s_instr);
         check("stall_hold_mis", 32'(ifid_misalign_o), 32'(s_mis));
      end
      if (req_hold) begin
         check("req_hold", 32'(imem_req_o), 32'd1);
         check("addr_hold", imem_addr_o, s_addr);
      end
      if (was_redir) check("redirect_flush", 32'(ifid_valid_o), 32'd0);
   endtask

   task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
      drive(st, rd, tgt);
      tick();
   endtask

   task automatic run_until_req(input int max);
      for (int i = 0; i < max && !imem_req_o; i++) step(1'b0, 1'b0, 32'h0);
      check("req_reached", 32'(imem_req_o), 32'd1);
   endtask

   initial begin
      int base;
      bit rd;
      logic [31:0] tgt;

      // Reset and reset state
      rst_i = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      rst_i = 1'b0;
      check("rst_pc", pc_o, IF_RESET_VECTOR);
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_ifid_valid", 32'(ifid_valid_o), 32'd0);
      check("rst_ifid_pc", ifid_pc_o, 32'h0);
      check("rst_ifid_instr", ifid_instr_o, IF_NOP_INSTR);
      check("rst_ifid_mis", 32'(ifid_misalign_o), 32'd0);
      run_until_req(4);
      check("first_addr", imem_addr_o, IF_RESET_VECTOR);

      // Back-to-back fetch at full speed: one instruction every two cycles
      gap_en = 1'b1;
      for (int i = 0; i < 20 && n_cons < 3; i++) step(1'b0, 1'b0, 32'h0);
      check("t1_count", 32'(n_cons), 32'd3);
      gap_en = 1'b0;

      // Stall with a live IF/ID: one more instruction parks in the skid buffer
      for (int i = 0; i < 10 && !ifid_valid_o; i++) step(1'b0, 1'b0, 32'h0);
      check("t2_valid", 32'(ifid_valid_o), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
      check("t2_req_low", 32'(imem_req_o), 32'd0);
      check("t2_pc_adv", pc_o, exp_pc + 32'd8);
      step(1'b0, 1'b0, 32'h0);
      check("t2_drain_valid", 32'(ifid_valid_o), 32'd1);
      check("t2_drain_pc", ifid_pc_o, exp_pc);

      // Redirect while waiting; the late response must be thrown away
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 20 && !(mem_pend && mem_wait == 1 && !imem_req_o); i++)
         step(1'b0, 1'b0, 32'h0);
      check("t3_in_wait", 32'(mem_pend && mem_wait == 1 && !imem_req_o), 32'd1);
      ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
      step(1'b0, 1'b1, 32'h0000_0100);
      step(1'b0, 1'b0, 32'h0);
      ovr_en = 1'b0;
      check("t3_drop_valid", 32'(ifid_valid_o), 32'd0);
      check("t3_req", 32'(imem_req_o), 32'd1);
      check("t3_addr", imem_addr_o, 32'h0000_0100);

      // Redirect while stalled with the skid buffer full
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 20 && !(ifid_valid_o && !imem_req_o && !mem_pend); i++)
         step(1'b1, 1'b0, 32'h0);
      check("t4_buf_full", 32'(ifid_valid_o && !imem_req_o && !mem_pend), 32'd1);
      step(1'b1, 1'b1, 32'h0000_0200);
      check("t4_req", 32'(imem_req_o), 32'd1);
      check("t4_addr", imem_addr_o, 32'h0000_0200);
      step(1'b1, 1'b0, 32'h0);
      check("t4_buf_flushed", 32'(ifid_valid_o), 32'd0);
      base = n_cons;
      for (int i = 0; i < 20 && n_cons < base + 2; i++) step(1'b0, 1'b0, 32'h0);
      check("t4_resume", 32'(n_cons >= base + 2), 32'd1);

      // Reset mid-transaction; the stale response arrives afterwards
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && !(mem_pend && mem_wait == 2 && !imem_req_o); i++)
         step(1'b0, 1'b0, 32'h0);
      check("t5_in_wait", 32'(mem_pend && mem_wait == 2), 32'd1);
      rst_i = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      rst_i = 1'b0;
      check("t5_pc", pc_o, IF_RESET_VECTOR);
      check("t5_req", 32'(imem_req_o), 32'd0);
      check("t5_ifid_valid", 32'(ifid_valid_o), 32'd0);
      run_until_req(10);
      check("t5_addr", imem_addr_o, IF_RESET_VECTOR);
      base = n_cons;
      for (int i = 0; i < 40 && n_cons < base + 2; i++) step(1'b0, 1'b0, 32'h0);
      check("t5_resume", 32'(n_cons >= base + 2), 32'd1);

      // Misaligned redirect target
      lat_min = 1; lat_max = 1;
      step(1'b0, 1'b1, 32'h0000_0102);
      run_until_req(10);
      check("t6_addr", imem_addr_o, 32'h0000_0100);
      for (int i = 0; i < 10 && !ifid_valid_o; i++) step(1'b0, 1'b0, 32'h0);
      check("t6_pc", ifid_pc_o, 32'h0000_0102);
      check("t6_misalign", 32'(ifid_misalign_o), 32'd1);

      // PC wrap through the top of the address space
      step(1'b0, 1'b1, 32'hFFFF_FFF8);
      base = n_cons;
      for (int i = 0; i < 30 && n_cons < base + 4; i++) step(1'b0, 1'b0, 32'h0);
      check("wrap_progress", 32'(n_cons >= base + 4), 32'd1);

      // Random traffic against the in-order stream model
      gnt_pct = 60; lat_min = 1; lat_max = 3;
      base = n_cons;
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(999) < 2);
         rd    = !rst_i && ($urandom_range(99) < 4);
         tgt   = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
         step($urandom_range(99) < 30, rd, tgt);
         if (rst_i || rd) last_cons_cyc = cyc;
         if (cyc - last_cons_cyc > 300) begin
            check("random_stuck", 32'(cyc - last_cons_cyc), 32'd0);
            last_cons_cyc = cyc;
         end
      end
      rst_i = 1'b0;
      check("random_progress", 32'(n_cons > base + 200), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_core_if_stage
`default_nettype wire
